mini_cpu: RTL and testbench

MINI_CPU -- requirements
Module: mini_cpu

---
 rtl/mini_cpu_pkg.sv | 52 +++++
 rtl/mini_cpu_alu.sv | 33 +++
 rtl/mini_cpu.sv | 104 ++++++++++
 tb/tb_mini_cpu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mini_cpu_pkg.sv
// Shared widths, opcode map and FSM encoding for the mini_cpu accumulator core.
// Optional multiply opcode is enabled by defining MINI_CPU_MUL_EN.
package mini_cpu_pkg;

    localparam int IW  = 16;
    localparam int AW  = 8;
    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_NOP = 4'h0;
    localparam logic [OPW-1:0] OP_LD  = 4'h1;
    localparam logic [OPW-1:0] OP_ADD = 4'h2;
    localparam logic [OPW-1:0] OP_SUB = 4'h3;
    localparam logic [OPW-1:0] OP_AND = 4'h4;
    localparam logic [OPW-1:0] OP_OR  = 4'h5;
    localparam logic [OPW-1:0] OP_XOR = 4'h6;
    localparam logic [OPW-1:0] OP_NOT = 4'h7;
    localparam logic [OPW-1:0] OP_SHL = 4'h8;
    localparam logic [OPW-1:0] OP_SHR = 4'h9;
    localparam logic [OPW-1:0] OP_LDI = 4'hA;
    localparam logic [OPW-1:0] OP_JMP = 4'hB;
    localparam logic [OPW-1:0] OP_JZ  = 4'hC;
    localparam logic [OPW-1:0] OP_JNZ = 4'hD;
    localparam logic [OPW-1:0] OP_MUL = 4'hE;
    localparam logic [OPW-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    // Branches test the accumulator as it stood before EXECUTE; HALT parks the fetch pointer.
    function automatic logic [AW-1:0] next_ipc(
        input logic [OPW-1:0] op,
        input logic [IW-1:0]  acc,
        input logic [AW-1:0]  ipc,
        input logic [AW-1:0]  imm
    );
        logic [AW-1:0] seq;
        seq = ipc + 8'd1;
        case (op)
            OP_JMP:  next_ipc = imm;
            OP_JZ:   next_ipc = (acc == 16'h0000) ? imm : seq;
            OP_JNZ:  next_ipc = (acc != 16'h0000) ? imm : seq;
            OP_HLT:  next_ipc = ipc;
            default: next_ipc = seq;
        endcase
    endfunction

endpackage

// File: rtl/mini_cpu_alu.sv
// Combinational accumulator ALU; result defaults to acc for non-arithmetic opcodes.
// MUL on opcode E exists only when MINI_CPU_MUL_EN is defined.
module mini_cpu_alu
    import mini_cpu_pkg::*;
(
    input  logic [OPW-1:0] op,
    input  logic [IW-1:0]  acc,
    input  logic [IW-1:0]  d,
    output logic [IW-1:0]  result
);

    // Opcode-selected accumulator update, all modulo 2^16.
    always_comb begin
        result = acc;
        case (op)
            OP_LD:   result = d;
            OP_ADD:  result = acc + d;
            OP_SUB:  result = acc - d;
            OP_AND:  result = acc & d;
            OP_OR:   result = acc | d;
            OP_XOR:  result = acc ^ d;
            OP_NOT:  result = ~acc;
            OP_SHL:  result = {acc[IW-2:0], 1'b0};
            OP_SHR:  result = {1'b0, acc[IW-1:1]};
            OP_LDI:  result = d;
`ifdef MINI_CPU_MUL_EN
            OP_MUL:  result = acc * d;
`endif
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/mini_cpu.sv
// Three-cycle-per-instruction accumulator CPU (FETCH/DECODE/EXECUTE) with HALT.
// Define MINI_CPU_MUL_EN to turn opcode E into MUL; otherwise it is a NOP.
module mini_cpu
    import mini_cpu_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [15:0]   PC,
    output logic [7:0]    ADDRESS,
    input  logic [15:0]   OUT_MEMORY,
    output logic [15:0]   MAR,
    output logic [15:0]   IN_ADDRESS_MEMORY,
    input  logic [15:0]   OUT_ADDRESS_MEMORY,
    output logic [15:0]   RESULT
);

    state_t          r_state;
    logic [AW-1:0]   r_ipc;
    logic [IW-1:0]   r_ir;
    logic [AW-1:0]   r_mar;
    logic [IW-1:0]   r_acc;

    logic [OPW-1:0]  w_op;
    logic [AW-1:0]   w_imm;
    logic [IW-1:0]   w_alu_d;
    logic [IW-1:0]   w_alu_result;
    logic [AW-1:0]   w_next_ipc;
    logic            w_unused;

    assign w_op     = r_ir[15:12];
    assign w_imm    = r_ir[7:0];
    assign w_unused = ^{PC[15:8], r_ir[11:8]};

    // LDI reuses the ALU load path with the zero-extended immediate as operand.
    always_comb begin
        if (w_op == OP_LDI) begin
            w_alu_d = {8'h00, w_imm};
        end else begin
            w_alu_d = OUT_ADDRESS_MEMORY;
        end
    end

    // Fetch-pointer update for the instruction held in IR.
    always_comb begin
        w_next_ipc = next_ipc(w_op, r_acc, r_ipc, w_imm);
    end

    mini_cpu_alu u_alu (
        .op     (w_op),
        .acc    (r_acc),
        .d      (w_alu_d),
        .result (w_alu_result)
    );

    // Control FSM and architectural registers; ACC only changes on the EXECUTE edge.
    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            r_state <= S_IDLE;
            r_ipc   <= 8'h00;
            r_ir    <= 16'h0000;
            r_mar   <= 8'h00;
            r_acc   <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // An X on PC makes the compare unknown, which keeps us parked here.
                    if (PC[7:0] != 8'h00) begin
                        r_ipc   <= PC[7:0];
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_ir    <= OUT_MEMORY;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_mar   <= w_imm;
                    r_state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    r_acc <= w_alu_result;
                    r_ipc <= w_next_ipc;
                    if (w_op == OP_HLT) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ADDRESS           = r_ipc;
    assign MAR               = {8'h00, r_mar};
    assign IN_ADDRESS_MEMORY = {8'h00, r_mar};
    assign RESULT            = r_acc;

endmodule

// File: tb/tb_mini_cpu.sv
// Self-checking bench for mini_cpu: instruction-level model plus directed programs.
module tb_mini_cpu;
    import mini_cpu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] PC = 16'h0000;
    logic [7:0]  ADDRESS;
    logic [15:0] OUT_MEMORY;
    logic [15:0] MAR;
    logic [15:0] IN_ADDRESS_MEMORY;
    logic [15:0] OUT_ADDRESS_MEMORY;
    logic [15:0] RESULT;

    logic [15:0] mem [0:255];
    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // model state: running/halted flags, phase inside the 3-cycle instruction
    logic        m_run, m_halt;
    logic [1:0]  m_phase;
    logic [7:0]  m_ipc, m_mar;
    logic [15:0] m_ir, m_acc;

    always #5 CLK = ~CLK;

    assign OUT_MEMORY         = mem[ADDRESS];
    assign OUT_ADDRESS_MEMORY = mem[IN_ADDRESS_MEMORY[7:0]];

    mini_cpu dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .PC                 (PC),
        .ADDRESS            (ADDRESS),
        .OUT_MEMORY         (OUT_MEMORY),
        .MAR                (MAR),
        .IN_ADDRESS_MEMORY  (IN_ADDRESS_MEMORY),
        .OUT_ADDRESS_MEMORY (OUT_ADDRESS_MEMORY),
        .RESULT             (RESULT)
    );

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] model_acc(input logic [3:0] op, input logic [15:0] acc,
                                              input logic [15:0] d, input logic [7:0] imm);
        case (op)
            4'h1: return d;
            4'h2: return acc + d;
            4'h3: return acc - d;
            4'h4: return acc & d;
            4'h5: return acc | d;
            4'h6: return acc ^ d;
            4'h7: return 16'hFFFF - acc;
            4'h8: return acc * 16'd2;
            4'h9: return acc / 16'd2;
            4'hA: return {8'h00, imm};
`ifdef MINI_CPU_MUL_EN
            4'hE: return acc * d;
`endif
            default: return acc;
        endcase
    endfunction

    function automatic logic [7:0] model_ipc(input logic [3:0] op, input logic [15:0] acc,
                                             input logic [7:0] ipc, input logic [7:0] imm);
        case (op)
            4'hB: return imm;
            4'hC: return (acc == 16'd0) ? imm : ipc + 8'd1;
            4'hD: return (acc != 16'd0) ? imm : ipc + 8'd1;
            4'hF: return ipc;
            default: return ipc + 8'd1;
        endcase
    endfunction

    // instruction-level reference: whole instruction takes effect on its third edge
    always @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            m_run <= 1'b0; m_halt <= 1'b0; m_phase <= 2'd0;
            m_ipc <= 8'd0; m_mar <= 8'd0; m_ir <= 16'd0; m_acc <= 16'd0;
        end else if (!m_run) begin
            if (!$isunknown(PC[7:0]) && PC[7:0] != 8'd0) begin
                m_run <= 1'b1; m_ipc <= PC[7:0]; m_phase <= 2'd0;
            end
        end else if (!m_halt) begin
            if (m_phase == 2'd0) begin
                m_ir <= mem[m_ipc]; m_phase <= 2'd1;
            end else if (m_phase == 2'd1) begin
                m_mar <= m_ir[7:0]; m_phase <= 2'd2;
            end else begin
                m_acc   <= model_acc(m_ir[15:12], m_acc, mem[m_mar], m_ir[7:0]);
                m_ipc   <= model_ipc(m_ir[15:12], m_acc, m_ipc, m_ir[7:0]);
                m_halt  <= (m_ir[15:12] == 4'hF);
                m_phase <= 2'd0;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            state_t es;
            if (!m_run)               es = S_IDLE;
            else if (m_halt)          es = S_HALT;
            else if (m_phase == 2'd0) es = S_FETCH;
            else if (m_phase == 2'd1) es = S_DECODE;
            else                      es = S_EXECUTE;
            check("cyc_address", {8'h00, ADDRESS}, {8'h00, m_ipc});
            check("cyc_result", RESULT, m_acc);
            check("cyc_mar", MAR, {8'h00, m_mar});
            check("cyc_in_addr", IN_ADDRESS_MEMORY, {8'h00, m_mar});
            check("cyc_state", 16'(dut.r_state), 16'(es));
        end
    end

    task automatic wait_halt(input int max_cyc);
        int n = 0;
        while (!m_halt && n < max_cyc) begin
            @(posedge CLK); #1;
            n++;
        end
        check("halt_reached", 16'(dut.r_state), 16'(S_HALT));
    endtask

    task automatic do_reset();
        @(negedge CLK); #2;
        RST_N = 1'b1;
        PC    = 16'h0000;
        @(negedge CLK); #2;
        RST_N = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        // program 1: LDI / ADD mem / SUB self / JNZ / HALT
        mem[100] = 16'hA005; mem[101] = 16'h20C8; mem[200] = 16'h0007;
        mem[102] = 16'h3066; mem[103] = 16'hD06E; mem[110] = 16'hF000;
        // program 2: every ALU opcode, JZ taken, JNZ not taken, JMP
        mem[20] = 16'hA0F0; mem[21] = 16'h2030; mem[22] = 16'h4031; mem[23] = 16'h5032;
        mem[24] = 16'h6033; mem[25] = 16'h7000; mem[26] = 16'h8000; mem[27] = 16'h9000;
        mem[28] = 16'h1034; mem[29] = 16'hC02C;
        mem[44] = 16'hD0FF; mem[45] = 16'h3035; mem[46] = 16'hE036; mem[47] = 16'hB040;
        mem[48] = 16'h1234; mem[49] = 16'h0FF0; mem[50] = 16'h8001; mem[51] = 16'hFFFF;
        mem[52] = 16'h0000; mem[53] = 16'h0001; mem[54] = 16'h0003; mem[64] = 16'hF000;
        // wrap: NOP at 255 falls through to HALT at 0
        mem[255] = 16'h0000; mem[0] = 16'hF000;

        #1 RST_N = 1'b1;
        #2;
        check("rst_result", RESULT, 16'h0000);
        check("rst_address", {8'h00, ADDRESS}, 16'h0000);
        check("rst_mar", MAR, 16'h0000);
        check("rst_in_addr", IN_ADDRESS_MEMORY, 16'h0000);
        chk_en = 1'b1;

        // idle hold with PC unknown, then zero
        @(negedge CLK); #2;
        RST_N = 1'b0;
        PC    = 16'hxxxx;
        repeat (5) @(negedge CLK);
        #2 PC = 16'h0000;
        repeat (5) @(posedge CLK);
        #1;
        check("idle_state", 16'(dut.r_state), 16'(S_IDLE));
        check("idle_result", RESULT, 16'h0000);
        check("idle_address", {8'h00, ADDRESS}, 16'h0000);

        // program 1
        @(negedge CLK); #2 PC = 16'd100;
        @(posedge CLK); #1;
        check("start_address", {8'h00, ADDRESS}, 16'd100);
        PC = 16'd7;
        repeat (3) @(posedge CLK); #1;
        check("ldi_result", RESULT, 16'h0005);
        check("ldi_address", {8'h00, ADDRESS}, 16'd101);
        repeat (2) @(posedge CLK); #1;
        check("exec_mar", MAR, 16'd200);
        check("exec_in_addr", IN_ADDRESS_MEMORY, 16'd200);
        @(posedge CLK); #1;
        check("add_result", RESULT, 16'h000C);
        wait_halt(30);
        check("sub_result", RESULT, 16'hCFA6);
        check("jnz_address", {8'h00, ADDRESS}, 16'd110);
        repeat (20) @(posedge CLK); #1;
        check("halt_result", RESULT, 16'hCFA6);
        check("halt_address", {8'h00, ADDRESS}, 16'd110);

        // program 2, aborted by reset during an EXECUTE with nonzero ACC
        do_reset();
        PC = 16'd20;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK); #2;
            if (m_run && m_phase == 2'd2 && m_acc != 16'd0) break;
        end
        check("pre_rst_state", 16'(dut.r_state), 16'(S_EXECUTE));
        RST_N = 1'b1;
        #1;
        check("async_result", RESULT, 16'h0000);
        check("async_address", {8'h00, ADDRESS}, 16'h0000);
        check("async_mar", MAR, 16'h0000);
        check("async_in_addr", IN_ADDRESS_MEMORY, 16'h0000);
        @(negedge CLK); #2;
        RST_N = 1'b0;
        PC    = 16'h0000;
        @(negedge CLK); #2;
        check("reentry_idle", 16'(dut.r_state), 16'(S_IDLE));
        PC = 16'd20;
        wait_halt(80);
`ifdef MINI_CPU_MUL_EN
        check("prog2_result", RESULT, 16'hFFFD);
`else
        check("prog2_result", RESULT, 16'hFFFF);
`endif
        check("prog2_address", {8'h00, ADDRESS}, 16'd64);

        // IPC wrap 255 -> 0
        do_reset();
        PC = 16'd255;
        @(posedge CLK); #1;
        check("wrap_start", {8'h00, ADDRESS}, 16'd255);
        repeat (3) @(posedge CLK); #1;
        check("wrap_address", {8'h00, ADDRESS}, 16'd0);
        wait_halt(10);
        check("wrap_halt_addr", {8'h00, ADDRESS}, 16'd0);

        @(negedge CLK);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
